// File: rtl/cga_pkg.sv
// ---------------------------------------------------------------------------
// cga_pkg
// Shared definitions for the CGA video RAM arbiter slice.
//   cga_state_e  : arbiter FSM states
//   CGA_RAM_AW   : default video RAM address width
//   CGA_FB_BASE  : ISA base address of the colour text/graphics framebuffer
// ---------------------------------------------------------------------------
package cga_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SLOT,
      ACCESS,
      CAPTURE,
      DONE
   } cga_state_e;

   localparam int CGA_RAM_AW = 19;

   localparam logic [19:0] CGA_FB_BASE = 20'hB8000;

endpackage

// File: rtl/cga_bus_sync.sv
// ---------------------------------------------------------------------------
// cga_bus_sync
// Brings one asynchronous, active-low ISA strobe into the clk domain through
// two flops and flags the cycle in which the synchronised strobe has just
// gone low.
// Ports:
//   clk      in  : system clock
//   nRESET   in  : asynchronous reset, active low (all flops reset to 1)
//   strobe_l in  : raw ISA strobe, active low, asynchronous
//   sync_l   out : synchronised strobe level
//   fall     out : one-cycle pulse on the synchronised falling edge
// ---------------------------------------------------------------------------
module cga_bus_sync (
   input  logic clk,
   input  logic nRESET,
   input  logic strobe_l,
   output logic sync_l,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Shift the strobe through the metastability flop, the synchronised flop
   // and a history flop used only for edge detection.
   always_comb begin
      meta_d = strobe_l;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Idle level of the strobe is high, so reset every stage to 1 to avoid a
   // spurious falling edge when reset is released.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_l = sync_q;
   assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/cga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// cga_vram_arbiter
// Shares the single CGA video RAM port between display fetch (absolute
// priority) and CPU reads/writes from the ISA bus. CPU accesses are placed
// only in the sequencer's isa_op_enable window, except when the watchdog
// expires. bus_rdy inserts ISA wait states when USE_BUS_WAIT=1.
// Ports:
//   clk, nRESET            : clock, asynchronous active-low reset
//   clk_seq                : sequencer phase (not needed for arbitration)
//   isa_op_enable          : CPU slot window
//   disp_req, disp_addr    : display fetch owns the RAM / its address
//   mem_cs, bus_a, bus_d   : framebuffer select, CPU offset, CPU write data
//   bus_memr_l, bus_memw_l : asynchronous ISA read/write strobes
//   ram_d                  : RAM read data (one-cycle latency)
//   ram_a, ram_dout, ram_we_l : RAM address, write data, write enable (low)
//   cpu_rdata              : captured CPU read data
//   bus_rdy                : ISA ready
//   busy                   : a CPU access is pending
// ---------------------------------------------------------------------------
module cga_vram_arbiter
   import cga_pkg::*;
#(
   parameter int USE_BUS_WAIT = 1,
   parameter int MAX_WAIT     = 63,
   parameter int RAM_AW       = CGA_RAM_AW
) (
   input  logic              clk,
   input  logic              nRESET,
   input  logic [4:0]        clk_seq,
   input  logic              isa_op_enable,
   input  logic              disp_req,
   input  logic [RAM_AW-1:0] disp_addr,
   input  logic              mem_cs,
   input  logic [14:0]       bus_a,
   input  logic              bus_memr_l,
   input  logic              bus_memw_l,
   input  logic [7:0]        bus_d,
   input  logic [7:0]        ram_d,
   output logic [RAM_AW-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_we_l,
   output logic [7:0]        cpu_rdata,
   output logic              bus_rdy,
   output logic              busy
);

   localparam int              WD_W     = $clog2(MAX_WAIT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_WAIT);

   cga_state_e        state_q, state_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [7:0]        dout_q, dout_d;
   logic              rdy_q, rdy_d;
   logic [WD_W-1:0]   wd_q, wd_d;

   logic rd_sync_l, rd_fall;
   logic wr_sync_l, wr_fall;
   logic req_start;
   logic strobe_released;
   logic slot_free;
   logic wd_expired;
   logic unused_seq;

   // The CPU window already encodes the sequencer phase, so clk_seq is only
   // carried through for debug visibility.
   assign unused_seq = ^clk_seq;

   cga_bus_sync u_rd_sync (
      .clk      (clk),
      .nRESET   (nRESET),
      .strobe_l (bus_memr_l),
      .sync_l   (rd_sync_l),
      .fall     (rd_fall)
   );

   cga_bus_sync u_wr_sync (
      .clk      (clk),
      .nRESET   (nRESET),
      .strobe_l (bus_memw_l),
      .sync_l   (wr_sync_l),
      .fall     (wr_fall)
   );

   assign req_start       = mem_cs & (rd_fall | wr_fall);
   assign strobe_released = we_q ? wr_sync_l : rd_sync_l;
   assign slot_free       = isa_op_enable & ~disp_req;
   assign wd_expired      = (wd_q == WD_LIMIT) & ~disp_req;

   // Next-state and datapath latches. A read whose strobe goes away before it
   // is granted is abandoned; a write is committed once latched. ACCESS holds
   // if the display grabs the port, so the CPU cycle is never lost to it.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      dout_d  = dout_q;
      wd_d    = '0;

      case (state_q)
         IDLE: begin
            if (req_start) begin
               addr_d        = '0;
               addr_d[14:0]  = bus_a;
               wdata_d       = bus_d;
               we_d          = wr_fall;
               state_d       = WAIT_SLOT;
            end
         end
         WAIT_SLOT: begin
            wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
            if (!we_q && rd_sync_l) begin
               state_d = IDLE;
            end else if (slot_free || wd_expired) begin
               state_d = ACCESS;
               if (we_q) begin
                  dout_d = wdata_q;
               end
            end
         end
         ACCESS: begin
            if (!disp_req) begin
               state_d = we_q ? DONE : CAPTURE;
            end
         end
         CAPTURE: begin
            rdata_d = ram_d;
            state_d = DONE;
         end
         DONE: begin
            if (strobe_released) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Ready follows the state one edge late on the way down so the request
      // is latched before the bus is stalled, but rises with DONE/abort.
      rdy_d = (state_q == IDLE) || (state_d == IDLE) || (state_d == DONE);
   end

   // State and datapath registers; reset drops any pending access.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b1;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         dout_q  <= dout_d;
         rdy_q   <= rdy_d;
         wd_q    <= wd_d;
      end
   end

   // Port mux: display always wins, and the write strobe is masked by it.
   assign ram_a     = disp_req ? disp_addr : addr_q;
   assign ram_we_l  = ~((state_q == ACCESS) & we_q & ~disp_req);
   assign ram_dout  = dout_q;
   assign cpu_rdata = rdata_q;
   assign busy      = (state_q == WAIT_SLOT) || (state_q == ACCESS) || (state_q == CAPTURE);
   assign bus_rdy   = (USE_BUS_WAIT != 0) ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cga_vram_arbiter
// Directed and randomised CPU transactions against a transaction-level model
// of the arbiter: for each access the bench picks the window/display pattern,
// computes the grant cycle from the arbitration rules, and derives the
// expected busy / bus_rdy / RAM port values for every cycle. A behavioural
// RAM answers the DUT; an independent image tracks what the CPU wrote.
// ---------------------------------------------------------------------------
module tb_cga_vram_arbiter;

   localparam int MAX_WAIT = 63;
   localparam int RAM_AW   = 19;
   localparam int SPAN     = 100;
   localparam int SYNC_LAT = 3;

   logic              clk = 1'b0;
   logic              nRESET;
   logic [4:0]        clk_seq = '0;
   logic              isa_op_enable;
   logic              disp_req;
   logic [RAM_AW-1:0] disp_addr;
   logic              mem_cs;
   logic [14:0]       bus_a;
   logic              bus_memr_l;
   logic              bus_memw_l;
   logic [7:0]        bus_d;
   logic [7:0]        ram_d;
   logic [RAM_AW-1:0] ram_a;
   logic [7:0]        ram_dout;
   logic              ram_we_l;
   logic [7:0]        cpu_rdata;
   logic              bus_rdy;
   logic              busy;

   int vectors     = 0;
   int miscompares = 0;

   logic       init_pending;
   logic [7:0] ram    [0:32767];
   logic [7:0] expmem [0:32767];

   cga_vram_arbiter #(
      .USE_BUS_WAIT (1),
      .MAX_WAIT     (MAX_WAIT),
      .RAM_AW       (RAM_AW)
   ) dut (
      .clk           (clk),
      .nRESET        (nRESET),
      .clk_seq       (clk_seq),
      .isa_op_enable (isa_op_enable),
      .disp_req      (disp_req),
      .disp_addr     (disp_addr),
      .mem_cs        (mem_cs),
      .bus_a         (bus_a),
      .bus_memr_l    (bus_memr_l),
      .bus_memw_l    (bus_memw_l),
      .bus_d         (bus_d),
      .ram_d         (ram_d),
      .ram_a         (ram_a),
      .ram_dout      (ram_dout),
      .ram_we_l      (ram_we_l),
      .cpu_rdata     (cpu_rdata),
      .bus_rdy       (bus_rdy),
      .busy          (busy)
   );

   // Free-running clock and sequencer phase.
   always #5 clk = ~clk;

   always @(posedge clk) clk_seq <= clk_seq + 5'd1;

   function automatic logic [7:0] initPattern(input int i);
      if (i == 32'h20) return 8'h5A;
      return 8'(i * 13 + 7);
   endfunction

   // Behavioural video RAM: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (init_pending) begin
         for (int i = 0; i < 32768; i++) ram[i] <= initPattern(i);
      end else begin
         if (!ram_we_l) ram[ram_a[14:0]] <= ram_dout;
         ram_d <= ram[ram_a[14:0]];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs just after the clock edge, then settle.
   task automatic applyStimulus(input logic rd_l, input logic wr_l, input logic cs,
                                input logic [14:0] a, input logic [7:0] d,
                                input logic isa, input logic disp, input logic [RAM_AW-1:0] da);
      @(posedge clk);
      #1;
      bus_memr_l    = rd_l;
      bus_memw_l    = wr_l;
      mem_cs        = cs;
      bus_a         = a;
      bus_d         = d;
      isa_op_enable = isa;
      disp_req      = disp;
      disp_addr     = da;
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".bus_rdy"},   32'(bus_rdy),   32'd1);
      checkOutput({tag, ".ram_we_l"},  32'(ram_we_l),  32'd1);
      checkOutput({tag, ".ram_dout"},  32'(ram_dout),  32'd0);
      checkOutput({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'd0);
      checkOutput({tag, ".busy"},      32'(busy),      32'd0);
   endtask

   // One CPU access. win_at: first WAIT_SLOT cycle with the window open
   // (-1 = never). disp_mode: 0 none, 1 random fetches, 2 fetch collides with
   // the first window. rel: cycle the strobe is released (-1 = once done).
   // Cycle k=0 is the first cycle after the request is recognised, which is
   // SYNC_LAT cycles after the strobe falls.
   task automatic runTxn(input bit wr, input logic [14:0] off, input logic [7:0] wdat,
                         input int win_at, input int disp_mode, input int rel);
      bit                isa_a  [SPAN];
      bit                disp_a [SPAN];
      logic [RAM_AW-1:0] da_a   [SPAN];
      int   g, done_at, r, busy_end, idle_at;
      bit   found, abort, strobe_low, isa_k, disp_k;
      logic [RAM_AW-1:0] da_k;
      string tg;

      for (int k = 0; k < SPAN; k++) begin
         isa_a[k]  = (win_at >= 0) && (k >= win_at);
         disp_a[k] = (disp_mode == 1 && k < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (disp_mode == 2 && k == win_at) disp_a[k] = 1'b1;
         da_a[k]   = {4'h0, 15'($urandom)};
      end

      // Grant: first free window, or the watchdog limit, with no fetch.
      g = SPAN - 1;
      found = 1'b0;
      for (int k = 0; k < SPAN; k++) begin
         if (!found && !disp_a[k] && (isa_a[k] || k >= MAX_WAIT)) begin
            g = k;
            found = 1'b1;
         end
      end
      for (int k = 0; k < SPAN; k++) if (k > g) disp_a[k] = 1'b0;

      done_at  = wr ? g + 2 : g + 3;
      r        = (rel < 0) ? done_at : rel;
      // A released strobe is seen two cycles later; reads abort if still waiting.
      abort    = !wr && (r + 2 <= g);
      busy_end = abort ? r + 3 : done_at;
      idle_at  = abort ? r + 3 : (((done_at > r + 2) ? done_at : r + 2) + 1);

      for (int k = -SYNC_LAT; k <= idle_at + 1; k++) begin
         strobe_low = (k < r);
         isa_k  = (k >= 0) ? isa_a[k] : 1'($urandom_range(0, 1));
         disp_k = (k >= 0) ? disp_a[k] : 1'b0;
         da_k   = (k >= 0) ? da_a[k] : '0;
         applyStimulus(wr ? 1'b1 : !strobe_low, wr ? !strobe_low : 1'b1, 1'b1,
                       off, wdat, isa_k, disp_k, da_k);
         tg = $sformatf("%s@%0d", wr ? "wr" : "rd", k);
         checkOutput({tg, ".busy"},     32'(busy),     32'(k >= 0 && k < busy_end));
         checkOutput({tg, ".bus_rdy"},  32'(bus_rdy),  32'(!(k >= 1 && k < busy_end)));
         checkOutput({tg, ".ram_we_l"}, 32'(ram_we_l), 32'(!(!abort && wr && k == g + 1)));
         if (disp_k) begin
            checkOutput({tg, ".ram_a_disp"}, 32'(ram_a), 32'(da_k));
         end else if (!abort && k == g + 1) begin
            checkOutput({tg, ".ram_a_cpu"}, 32'(ram_a), 32'(off));
            if (wr) checkOutput({tg, ".ram_dout"}, 32'(ram_dout), 32'(wdat));
         end
         if (!abort && !wr && k == done_at) begin
            checkOutput({tg, ".cpu_rdata"}, 32'(cpu_rdata), 32'(expmem[off]));
         end
      end
      if (wr) expmem[off] = wdat;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) expmem[i] = initPattern(i);
      init_pending  = 1'b1;
      nRESET        = 1'b1;
      bus_memr_l    = 1'b1;
      bus_memw_l    = 1'b1;
      mem_cs        = 1'b0;
      bus_a         = '0;
      bus_d         = '0;
      isa_op_enable = 1'b0;
      disp_req      = 1'b0;
      disp_addr     = '0;

      #1 nRESET = 1'b0;
      #1 checkResetValues("reset");
      @(posedge clk);
      #1 init_pending = 1'b0;
      @(posedge clk);
      #2 nRESET = 1'b1;

      $display("[TB] directed accesses");
      runTxn(1'b1, 15'h0010, 8'h41, 5, 0, -1);
      runTxn(1'b0, 15'h0020, 8'h00, 0, 0, -1);
      runTxn(1'b0, 15'h0010, 8'h00, 1, 0, -1);
      runTxn(1'b1, 15'h0321, 8'h9C, 2, 2, -1);
      runTxn(1'b0, 15'h0321, 8'h00, 4, 2, -1);
      runTxn(1'b1, 15'h1234, 8'h77, -1, 0, -1);
      runTxn(1'b0, 15'h1234, 8'h00, -1, 0, -1);
      runTxn(1'b0, 15'h0040, 8'h00, 10, 0, 1);
      runTxn(1'b1, 15'h0050, 8'hE5, 10, 0, 1);
      runTxn(1'b0, 15'h0050, 8'h00, 0, 0, -1);

      $display("[TB] strobe outside the framebuffer");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 15'h0060, 8'h11, 1'b1, 1'b0, '0);
         checkOutput($sformatf("nocs@%0d.busy", k), 32'(busy), 32'd0);
         checkOutput($sformatf("nocs@%0d.we", k), 32'(ram_we_l), 32'd1);
      end
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b1, 15'h0060, 8'h11, 1'b0, 1'b0, '0);

      $display("[TB] randomised accesses");
      for (int t = 0; t < 14; t++) begin
         runTxn(1'($urandom_range(0, 1)), {7'h0, 8'($urandom)}, 8'($urandom),
                int'($urandom_range(0, 8)), int'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
      end

      $display("[TB] reset during a pending write");
      for (int k = -SYNC_LAT; k <= 5; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 15'h0123, 8'hC3, 1'b0, 1'b0, '0);
      end
      checkOutput("rstmid.busy_before", 32'(busy), 32'd1);
      #1 nRESET = 1'b0;
      #1 checkResetValues("rstmid");
      bus_memw_l = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 nRESET = 1'b1;
      for (int k = 0; k < 80; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 15'h0123, 8'hC3, 1'b1, 1'b0, '0);
         checkOutput($sformatf("rstmid@%0d.we", k), 32'(ram_we_l), 32'd1);
         checkOutput($sformatf("rstmid@%0d.busy", k), 32'(busy), 32'd0);
      end
      runTxn(1'b0, 15'h0123, 8'h00, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
